router_switch: RTL and testbench

- Switching core of the 4-port router.
- Sits between the four inbound packet consumers, which deliver assembled 32-bit packets, and the four outbound packet producers, which serialize them to neighbours.
- Buffers each input in a FIFO, looks up the output port from the packet destID, and arbitrates round-robin per output port.
- Presents one registered packet per output under a valid/ready handshake.

---
 rtl/router_switch.sv | 160 ++++++++++++++++
 tb/tb_router_switch.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/router_switch.sv
// Switching core of the 4-port router: per-input FIFOs, destID route lookup,
// round-robin arbitration per output and one registered packet slot per output.
module router_switch #(
  parameter int unsigned DEPTH       = 4,
  parameter logic [31:0] ROUTE_TABLE = 32'h0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0][31:0] pkt_in,
  input  logic [3:0]      pkt_in_avail,
  output logic [3:0]      in_full,
  output logic [3:0][31:0] pkt_out,
  output logic [3:0]      pkt_out_valid,
  input  logic [3:0]      pkt_out_ready,
  output logic [7:0]      drop_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0]     mem_q [4][DEPTH];
  logic [AW-1:0]   rd_ptr_q [4];
  logic [AW-1:0]   rd_ptr_d [4];
  logic [AW-1:0]   wr_ptr_q [4];
  logic [AW-1:0]   wr_ptr_d [4];
  logic [CW-1:0]   cnt_q [4];
  logic [CW-1:0]   cnt_d [4];
  logic [31:0]     head [4];
  logic [1:0]      req_port [4];
  logic [3:0]      head_vld;
  logic [3:0]      full;
  logic [3:0]      push;
  logic [3:0]      pop;
  logic [3:0]      drop;
  logic [2:0]      n_drop;
  logic [1:0]      rr_q [4];
  logic [1:0]      rr_d [4];
  logic [1:0]      gnt_idx [4];
  logic [3:0]      gnt;
  logic [3:0][31:0] pkt_out_q;
  logic [3:0][31:0] pkt_out_d;
  logic [3:0]      vld_q;
  logic [3:0]      vld_d;
  logic [7:0]      drop_q;
  logic [7:0]      drop_d;

  function automatic logic [1:0] route_of(input logic [3:0] dest);
    return ROUTE_TABLE[{dest, 1'b0} +: 2];
  endfunction

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [2:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {6'd0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  always_comb begin
    for (int j = 0; j < 4; j++) begin
      head[j]     = mem_q[j][rd_ptr_q[j]];
      head_vld[j] = (cnt_q[j] != '0);
      req_port[j] = route_of(head[j][27:24]);
      full[j]     = (cnt_q[j] == FULL_CNT);
    end
  end

  // Round-robin scan per output, starting at rr_q; grant only into a free slot.
  always_comb begin : arb
    logic       found;
    logic [1:0] idx;
    found = 1'b0;
    idx   = '0;
    gnt   = '0;
    pop   = '0;
    for (int o = 0; o < 4; o++) begin
      gnt_idx[o] = rr_q[o];
      found      = 1'b0;
      for (int k = 0; k < 4; k++) begin
        idx = rr_q[o] + 2'(k);
        if (!found && head_vld[idx] && (req_port[idx] == 2'(o))) begin
          found      = 1'b1;
          gnt_idx[o] = idx;
        end
      end
      if (found && (!vld_q[o] || pkt_out_ready[o])) begin
        gnt[o]          = 1'b1;
        pop[gnt_idx[o]] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int o = 0; o < 4; o++) begin
      pkt_out_d[o] = pkt_out_q[o];
      vld_d[o]     = vld_q[o];
      rr_d[o]      = rr_q[o];
      if (gnt[o]) begin
        pkt_out_d[o] = head[gnt_idx[o]];
        vld_d[o]     = 1'b1;
        rr_d[o]      = gnt_idx[o] + 2'd1;
      end else if (vld_q[o] && pkt_out_ready[o]) begin
        vld_d[o] = 1'b0;
      end
    end
  end

  // A full FIFO still accepts a push when its head leaves in the same cycle.
  always_comb begin
    n_drop = '0;
    for (int j = 0; j < 4; j++) begin
      push[j]     = pkt_in_avail[j] && (!full[j] || pop[j]);
      drop[j]     = pkt_in_avail[j] && !push[j];
      n_drop      = n_drop + {2'b00, drop[j]};
      wr_ptr_d[j] = push[j] ? wr_ptr_q[j] + AW'(1) : wr_ptr_q[j];
      rd_ptr_d[j] = pop[j]  ? rd_ptr_q[j] + AW'(1) : rd_ptr_q[j];
      case ({push[j], pop[j]})
        2'b10:   cnt_d[j] = cnt_q[j] + CW'(1);
        2'b01:   cnt_d[j] = cnt_q[j] - CW'(1);
        default: cnt_d[j] = cnt_q[j];
      endcase
    end
    drop_d = sat_add8(drop_q, n_drop);
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < 4; j++) begin
      if (push[j]) mem_q[j][wr_ptr_q[j]] <= pkt_in[j];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < 4; j++) begin
        rd_ptr_q[j] <= '0;
        wr_ptr_q[j] <= '0;
        cnt_q[j]    <= '0;
        rr_q[j]     <= '0;
      end
      pkt_out_q <= '0;
      vld_q     <= '0;
      drop_q    <= '0;
    end else begin
      for (int j = 0; j < 4; j++) begin
        rd_ptr_q[j] <= rd_ptr_d[j];
        wr_ptr_q[j] <= wr_ptr_d[j];
        cnt_q[j]    <= cnt_d[j];
        rr_q[j]     <= rr_d[j];
      end
      pkt_out_q <= pkt_out_d;
      vld_q     <= vld_d;
      drop_q    <= drop_d;
    end
  end

  assign in_full       = full;
  assign pkt_out       = pkt_out_q;
  assign pkt_out_valid = vld_q;
  assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_router_switch.sv
// Directed bench for router_switch: latency, contention order, backpressure,
// full-with-pop, drop saturation and asynchronous reset mid-flight.
module tb_router_switch;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0][31:0] pkt_in;
  logic [3:0]       pkt_in_avail;
  logic [3:0]       in_full;
  logic [3:0][31:0] pkt_out;
  logic [3:0]       pkt_out_valid;
  logic [3:0]       pkt_out_ready;
  logic [7:0]       drop_cnt;

  int vectors = 0;
  int miscompares = 0;

  router_switch #(.DEPTH(4), .ROUTE_TABLE(32'hE4E4_E4E4)) dut (
    .clk           (clk),
    .rst           (rst),
    .pkt_in        (pkt_in),
    .pkt_in_avail  (pkt_in_avail),
    .in_full       (in_full),
    .pkt_out       (pkt_out),
    .pkt_out_valid (pkt_out_valid),
    .pkt_out_ready (pkt_out_ready),
    .drop_cnt      (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mkpkt(input logic [3:0] s, input logic [3:0] d,
                                        input logic [23:0] dat);
    return {s, d, dat};
  endfunction

  logic [31:0] exp_q [6];
  int          ord [4];

  initial begin
    rst           = 1'b1;
    pkt_in        = '0;
    pkt_in_avail  = '0;
    pkt_out_ready = 4'hF;
    repeat (3) @(negedge clk);
    chk("rst_in_full", 32'(in_full), 32'h0);
    chk("rst_valid", 32'(pkt_out_valid), 32'h0);
    chk("rst_pkt_out0", pkt_out[0], 32'h0);
    chk("rst_pkt_out3", pkt_out[3], 32'h0);
    chk("rst_drop", 32'(drop_cnt), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // single packet, destID 3 -> port 3, two-cycle latency, one-cycle valid
    pkt_in[0]    = 32'h1300_ABCD;
    pkt_in_avail = 4'b0001;
    @(negedge clk);
    pkt_in_avail = 4'b0000;
    chk("single_early", 32'(pkt_out_valid), 32'h0);
    @(negedge clk);
    chk("single_valid", 32'(pkt_out_valid), 32'h8);
    chk("single_data", pkt_out[3], 32'h1300_ABCD);
    @(negedge clk);
    chk("single_after", 32'(pkt_out_valid), 32'h0);

    // contention on port 2 from inputs 0,1,2 with rr[2]=0
    for (int j = 0; j < 3; j++) pkt_in[j] = mkpkt(4'(j), 4'h2, 24'h00C000 + 24'(j));
    pkt_in_avail = 4'b0111;
    @(negedge clk);
    pkt_in_avail = 4'b0000;
    chk("cont1_early", 32'(pkt_out_valid), 32'h0);
    exp_q[0] = 32'h0200_C000;
    exp_q[1] = 32'h1200_C001;
    exp_q[2] = 32'h2200_C002;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("cont1_valid%0d", k), 32'(pkt_out_valid), 32'h4);
      chk($sformatf("cont1_data%0d", k), pkt_out[2], exp_q[k]);
    end
    @(negedge clk);
    chk("cont1_after", 32'(pkt_out_valid), 32'h0);

    // all four inputs to port 2; rr[2]=3 so input 3 goes first
    for (int j = 0; j < 4; j++) pkt_in[j] = mkpkt(4'(j), 4'h2, 24'h00D000 + 24'(j));
    pkt_in_avail = 4'b1111;
    @(negedge clk);
    pkt_in_avail = 4'b0000;
    ord = '{3, 0, 1, 2};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("cont2_valid%0d", k), 32'(pkt_out_valid), 32'h4);
      chk($sformatf("cont2_data%0d", k), pkt_out[2],
          mkpkt(4'(ord[k]), 4'h2, 24'h00D000 + 24'(ord[k])));
    end
    @(negedge clk);
    chk("cont2_after", 32'(pkt_out_valid), 32'h0);

    // backpressure on port 1: A held in slot, B..E fill FIFO 0, F dropped
    pkt_out_ready = 4'b1101;
    for (int k = 0; k < 6; k++) begin
      exp_q[k]     = mkpkt(4'h0, 4'h1, 24'hA00000 + 24'(k));
      pkt_in[0]    = exp_q[k];
      pkt_in_avail = 4'b0001;
      @(negedge clk);
    end
    pkt_in_avail = 4'b0000;
    chk("bp_in_full", 32'(in_full), 32'h1);
    chk("bp_drop", 32'(drop_cnt), 32'h1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("bp_hold_valid%0d", k), 32'(pkt_out_valid), 32'h2);
      chk($sformatf("bp_hold_data%0d", k), pkt_out[1], exp_q[0]);
    end

    // full-with-pop: ready rises while G is strobed into the full FIFO
    pkt_out_ready = 4'hF;
    pkt_in[0]     = mkpkt(4'h0, 4'h1, 24'hA0000F);
    pkt_in_avail  = 4'b0001;
    chk("drain_A", pkt_out[1], exp_q[0]);
    @(negedge clk);
    pkt_in_avail = 4'b0000;
    chk("fwp_drop", 32'(drop_cnt), 32'h1);
    chk("fwp_in_full", 32'(in_full), 32'h1);
    chk("drain_B", pkt_out[1], exp_q[1]);
    chk("drain_B_valid", 32'(pkt_out_valid), 32'h2);
    for (int k = 2; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("drain_%0d", k), pkt_out[1], exp_q[k]);
      chk($sformatf("drain_valid%0d", k), 32'(pkt_out_valid), 32'h2);
    end
    @(negedge clk);
    chk("drain_G", pkt_out[1], 32'h01A0_000F);
    @(negedge clk);
    chk("drain_after", 32'(pkt_out_valid), 32'h0);
    chk("drain_in_full", 32'(in_full), 32'h0);

    // drop saturation: fill FIFOs 0 and 1 behind blocked port 1
    pkt_out_ready = 4'b1101;
    pkt_in[0]     = mkpkt(4'h0, 4'h1, 24'h000005);
    pkt_in[1]     = mkpkt(4'h1, 4'h1, 24'h000006);
    pkt_in_avail  = 4'b0001;
    repeat (5) @(negedge clk);
    pkt_in_avail = 4'b0010;
    repeat (4) @(negedge clk);
    chk("sat_pre_drop", 32'(drop_cnt), 32'h1);
    pkt_in_avail = 4'b0011;
    @(negedge clk);
    chk("sat_dual_drop", 32'(drop_cnt), 32'h3);
    chk("sat_in_full", 32'(in_full), 32'h3);
    repeat (300) @(negedge clk);
    pkt_in_avail = 4'b0000;
    chk("sat_drop_ff", 32'(drop_cnt), 32'hFF);
    @(negedge clk);
    chk("sat_hold_ff", 32'(drop_cnt), 32'hFF);

    rst = 1'b1;
    #1;
    chk("rst2_drop", 32'(drop_cnt), 32'h0);
    chk("rst2_in_full", 32'(in_full), 32'h0);
    chk("rst2_valid", 32'(pkt_out_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // reset mid-flight: P0 in port-2 slot, P1..P3 buffered
    pkt_out_ready = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      pkt_in[3]    = mkpkt(4'h3, 4'h2, 24'h0000D0 + 24'(k));
      pkt_in_avail = 4'b1000;
      @(negedge clk);
    end
    pkt_in_avail = 4'b0000;
    chk("mid_valid", 32'(pkt_out_valid), 32'h4);
    chk("mid_data", pkt_out[2], 32'h3200_00D0);
    chk("mid_in_full", 32'(in_full), 32'h0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_valid", 32'(pkt_out_valid), 32'h0);
    chk("async_data", pkt_out[2], 32'h0);
    @(negedge clk);
    rst           = 1'b0;
    pkt_out_ready = 4'hF;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst_valid%0d", k), 32'(pkt_out_valid), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
